dlsc_sp605_ch7301c_init: RTL and testbench
==========================================

DLSC_SP605_CH7301C_INIT -- requirements
Module: dlsc_sp605_ch7301c_init

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 125: clk cycles per SCL quarter-period (125 gives 100 kHz at 50 MHz).
REQ-002 The block SHALL have parameter INIT_DELAY, default 50000: clk cycles from reset release to the first START.
REQ-003 The block SHALL have parameter DEV_ADDR, default 7'h76: 7-bit I2C address of the CH7301C.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port scl_oe, output, 1 bit: 1 drives SCL low, 0 releases it.
REQ-007 The block SHALL have port sda_oe, output, 1 bit: 1 drives SDA low, 0 releases it.
REQ-008 The block SHALL have port sda_in, input, 1 bit: sampled SDA pad level.
REQ-009 The block SHALL have port done, output, 1 bit: all writes completed and acknowledged.
REQ-010 The block SHALL have port error, output, 1 bit: a write was NACKed.
REQ-011 The block SHALL have port px_en, output, 1 bit: pixel-output enable for the DVI output block, equal to done.

Function
REQ-012 The block SHALL hold a fixed 8-entry table of {reg, data} writes, in order: {1C,00}, {1D,45}, {1F,80}, {21,09}, {33,08}, {34,16}, {36,60}, {49,C0}.
REQ-013 The FSM states SHALL be WAIT, START, SHIFT, ACK, STOP, GAP, DONE, ERR.
- WAIT: counts INIT_DELAY cycles, then goes to START.
- GAP: idles 4 quarters, then advances the entry index and goes to START; after entry 7 it goes to DONE.
REQ-014 Each write SHALL be START, then 3 bytes MSB-first ({DEV_ADDR,0}, reg, data), each followed by an ACK bit, then STOP.
REQ-015 Each bit SHALL occupy 4 quarters of CLK_DIV cycles each:
- q0: SCL low, SDA updated.
- q1 and q2: SCL released.
- q3: SCL low.
REQ-016 START SHALL release SDA and SCL for 2 quarters, then drive SDA low with SCL released for 2 quarters.
REQ-017 STOP SHALL drive SDA low with SCL low for 1 quarter, release SCL for 1 quarter, then release SDA for 2 quarters.
REQ-018 During ACK the block SHALL release SDA and sample sda_in on the last cycle of q2; 0 is ACK, 1 is NACK.
REQ-019 On NACK the block SHALL issue STOP and then enter ERR.
REQ-020 In ERR, error SHALL be 1, done SHALL be 0, and the block SHALL stay in ERR until reset.
REQ-021 In DONE, done and px_en SHALL be 1 and the bus SHALL be released, until reset.
REQ-022 A full write SHALL take exactly (4 START + 27×4 bit + 4 STOP) quarters = 116×CLK_DIV cycles; GAP SHALL add 4×CLK_DIV cycles.
REQ-023 The quarter counter SHALL be wide enough for CLK_DIV-1 and SHALL wrap to 0 at each quarter boundary; the bit counter SHALL cover 0..8.

Reset
REQ-024 On rst, the block SHALL asynchronously clear:
- state to WAIT;
- all counters and the entry index to 0;
- scl_oe, sda_oe, done, error and px_en to 0.
REQ-025 Reset asserted mid-transaction SHALL immediately release both bus lines, and the block SHALL restart the whole sequence, including INIT_DELAY, after rst deasserts.

Configuration
REQ-026 With DLSC_CH7301C_RETRY_EN defined, a NACKed write SHALL be retried from START after GAP, up to 3 retries per entry, before entering ERR; the retry count SHALL clear on each ACKed write.
REQ-027 Without DLSC_CH7301C_RETRY_EN, the first NACK SHALL lead to ERR.

Verification
REQ-028 CLK_DIV=4, INIT_DELAY=10, I2C slave model ACKing everything -> 8 decoded writes matching REQ-012 in order with address byte 0xEC; done=px_en=1 at cycle 10+8×120×4 ±2.
REQ-029 Slave NACKs the data byte of entry 3 (reg 21), no macro -> STOP issued, error=1, done=px_en=0, and no further START is observed.
REQ-030 With DLSC_CH7301C_RETRY_EN, slave NACKs entry 2 twice and then ACKs -> entry 2 is seen 3 times, all 8 entries complete, done=1, error=0.
REQ-031 With DLSC_CH7301C_RETRY_EN, slave always NACKs entry 0 -> 4 attempts, then error=1.
REQ-032 rst pulsed while bit 5 of entry 4 is on the bus -> scl_oe=sda_oe=0 in the same cycle; the sequence restarts from entry 0 after INIT_DELAY.
REQ-033 The bench SHALL check on every cycle that SDA changes only while SCL is low, except within START and STOP.

Source files
------------

// File: rtl/dlsc_sp605_ch7301c_init.sv
// rtl/dlsc_sp605_ch7301c_init.sv - SP605 CH7301C DVI transmitter I2C register init sequencer
// Optional feature macro: DLSC_CH7301C_RETRY_EN (retry a NACKed write up to 3 times before ERR)
module dlsc_sp605_ch7301c_init #(
  parameter int         CLK_DIV    = 125,
  parameter int         INIT_DELAY = 50000,
  parameter logic [6:0] DEV_ADDR   = 7'h76
) (
  input  logic clk,
  input  logic rst,
  output logic scl_oe,
  output logic sda_oe,
  input  logic sda_in,
  output logic done,
  output logic error,
  output logic px_en
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(INIT_DELAY - 1);

  typedef enum logic [2:0] {
    S_WAIT, S_START, S_SHIFT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   wait_cnt;
  logic [QW-1:0]   qcnt;       // clk cycle within the current quarter
  logic [1:0]      quarter;    // quarter within the current bit/START/STOP/GAP
  logic [3:0]      bit_cnt;    // 0..7 data bits, 8 while in the ACK slot
  logic [1:0]      byte_idx;   // 0 = address, 1 = register, 2 = data
  logic [2:0]      entry;
  logic            nacked;     // slave answered NACK in this write
  logic            can_retry;
  logic            q_end, phase_end;
  logic [15:0]     wr_word;
  logic [7:0]      cur_byte;
  logic            cur_bit;

  assign q_end     = (qcnt == Q_LAST);
  assign phase_end = q_end && (quarter == 2'd3);

`ifdef DLSC_CH7301C_RETRY_EN
  logic [1:0] retry_cnt;
  assign can_retry = (retry_cnt != 2'd3);

  // Retries spent on the current entry; cleared once the entry is acknowledged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= 2'd0;
    end else if (state == S_GAP && phase_end) begin
      retry_cnt <= nacked ? retry_cnt + 2'd1 : 2'd0;
    end
  end
`else
  assign can_retry = 1'b0;
`endif

  // Fixed {reg, data} write table for the CH7301C bring-up
  always_comb begin
    wr_word = 16'h0000;
    case (entry)
      3'd0: wr_word = 16'h1C00;
      3'd1: wr_word = 16'h1D45;
      3'd2: wr_word = 16'h1F80;
      3'd3: wr_word = 16'h2109;
      3'd4: wr_word = 16'h3308;
      3'd5: wr_word = 16'h3416;
      3'd6: wr_word = 16'h3660;
      3'd7: wr_word = 16'h49C0;
      default: wr_word = 16'h0000;
    endcase
  end

  // Pick the byte on the wire and its current MSB-first bit
  always_comb begin
    cur_byte = {DEV_ADDR, 1'b0};
    if (byte_idx == 2'd1) cur_byte = wr_word[15:8];
    else if (byte_idx == 2'd2) cur_byte = wr_word[7:0];
  end
  assign cur_bit = cur_byte[3'd7 - bit_cnt[2:0]];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nx;
  end

  // Timing counters, byte/bit/entry sequencing and ACK sampling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      qcnt     <= '0;
      quarter  <= 2'd0;
      bit_cnt  <= 4'd0;
      byte_idx <= 2'd0;
      entry    <= 3'd0;
      nacked   <= 1'b0;
    end else begin
      if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;

      if (state inside {S_WAIT, S_DONE, S_ERR}) begin
        qcnt    <= '0;
        quarter <= 2'd0;
      end else if (q_end) begin
        qcnt    <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        qcnt <= qcnt + 1'b1;
      end

      if (phase_end) begin
        case (state)
          S_START: begin
            bit_cnt  <= 4'd0;
            byte_idx <= 2'd0;
          end
          S_SHIFT: bit_cnt <= bit_cnt + 4'd1;
          S_ACK: begin
            bit_cnt  <= 4'd0;
            byte_idx <= byte_idx + 2'd1;
          end
          S_GAP: if (!nacked && entry != 3'd7) entry <= entry + 3'd1;
          default: ;
        endcase
      end

      if (state == S_START) nacked <= 1'b0;
      else if (state == S_ACK && quarter == 2'd2 && q_end) nacked <= sda_in;
    end
  end

  // Next state and bus drive for each quarter of START/bit/ACK/STOP
  always_comb begin
    state_nx = state;
    scl_oe   = 1'b0;
    sda_oe   = 1'b0;
    case (state)
      S_WAIT: if (wait_cnt == D_LAST) state_nx = S_START;
      S_START: begin
        sda_oe = quarter[1];
        if (phase_end) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        scl_oe = (quarter == 2'd0) || (quarter == 2'd3);
        sda_oe = ~cur_bit;
        if (phase_end && bit_cnt == 4'd7) state_nx = S_ACK;
      end
      S_ACK: begin
        scl_oe = (quarter == 2'd0) || (quarter == 2'd3);
        if (phase_end) state_nx = (nacked || byte_idx == 2'd2) ? S_STOP : S_SHIFT;
      end
      S_STOP: begin
        scl_oe = (quarter == 2'd0);
        sda_oe = ~quarter[1];
        if (phase_end) state_nx = (nacked && !can_retry) ? S_ERR : S_GAP;
      end
      S_GAP: if (phase_end) state_nx = (!nacked && entry == 3'd7) ? S_DONE : S_START;
      S_DONE, S_ERR: ;
      default: state_nx = S_WAIT;
    endcase
  end

  assign done  = (state == S_DONE);
  assign error = (state == S_ERR);
  assign px_en = done;

endmodule

// File: tb/tb_dlsc_sp605_ch7301c_init.sv
// tb/tb_dlsc_sp605_ch7301c_init.sv - self-checking bench for dlsc_sp605_ch7301c_init
module tb_dlsc_sp605_ch7301c_init;

  localparam int CLK_DIV    = 4;
  localparam int INIT_DELAY = 10;
`ifdef DLSC_CH7301C_RETRY_EN
  localparam int MAX_RETRY = 3;
`else
  localparam int MAX_RETRY = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_oe, sda_oe, sda_in, done, error, px_en;
  logic slv_low = 1'b0;

  assign sda_in = ~(sda_oe | slv_low);

  dlsc_sp605_ch7301c_init #(
    .CLK_DIV    (CLK_DIV),
    .INIT_DELAY (INIT_DELAY),
    .DEV_ADDR   (7'h76)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .scl_oe (scl_oe),
    .sda_oe (sda_oe),
    .sda_in (sda_in),
    .done   (done),
    .error  (error),
    .px_en  (px_en)
  );

  always #5 clk = ~clk;

  logic [15:0] table_w [8] = '{16'h1C00, 16'h1D45, 16'h1F80, 16'h2109,
                               16'h3308, 16'h3416, 16'h3660, 16'h49C0};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cyc = -1;
  bit active = 1'b0;

  // slave NACK policy: entry nk_entry NACKs byte nk_byte on its first nk_times attempts
  int nk_entry = -1, nk_byte = 0, nk_times = 0;

  function automatic int nack_pos(input int e, input int a);
    return (e == nk_entry && a < nk_times) ? nk_byte : 3;
  endfunction

  function automatic logic [7:0] wbyte(input int e, input int b);
    logic [15:0] w;
    w = table_w[e];
    if (b == 0) return 8'hEC;
    else if (b == 1) return w[15:8];
    else return w[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // expected bus per quarter: {start/stop quarter, scl_oe, sda_oe}
  logic [2:0]  exp_q[$];
  logic [23:0] exp_writes[$];
  int          exp_starts;
  logic        exp_done, exp_err;

  task automatic push4(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
  endtask

  task automatic build_model();
    int e, att, np;
    logic [7:0] by;
    bit fin;
    exp_q.delete(); exp_writes.delete();
    exp_starts = 0; exp_done = 1'b0; exp_err = 1'b0;
    e = 0; att = 0; fin = 1'b0;
    while (!fin) begin
      np = nack_pos(e, att);
      exp_starts++;
      push4(3'b100, 3'b100, 3'b101, 3'b101);
      for (int b = 0; b < 3; b++) begin
        by = wbyte(e, b);
        for (int i = 7; i >= 0; i--)
          push4({2'b01, ~by[i]}, {2'b00, ~by[i]}, {2'b00, ~by[i]}, {2'b01, ~by[i]});
        push4(3'b010, 3'b000, 3'b000, 3'b010);
        if (np == b) break;
      end
      push4(3'b111, 3'b101, 3'b100, 3'b100);
      if (np < 3) begin
        if (att < MAX_RETRY) begin
          push4(3'b000, 3'b000, 3'b000, 3'b000);
          att++;
        end else begin
          exp_err = 1'b1;
          fin = 1'b1;
        end
      end else begin
        exp_writes.push_back({8'hEC, table_w[e]});
        push4(3'b000, 3'b000, 3'b000, 3'b000);
        e++; att = 0;
        if (e == 8) begin
          exp_done = 1'b1;
          fin = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) cyc = 0;
    else     cyc++;
  end

  // I2C slave: decodes START/bytes/STOP from the bus and answers ACK/NACK
  int          got_starts = 0;
  logic [23:0] got_writes[$];
  logic        p_scl = 1'b1, p_sda = 1'b1, in_frame = 1'b0, w_nack = 1'b0;
  logic        scl_l, sda_l;
  int          bitc = 0, bytec = 0, s_entry = 0, s_att = 0;
  logic [7:0]  sh = 8'h00;
  logic [23:0] wr = 24'h0;

  always @(negedge clk) begin
    scl_l = !scl_oe;
    sda_l = !sda_oe;
    if (rst) begin
      in_frame = 1'b0; w_nack = 1'b0; slv_low = 1'b0;
      got_starts = 0; got_writes.delete();
      s_entry = 0; s_att = 0; p_scl = 1'b1; p_sda = 1'b1;
    end else begin
      if (scl_l && p_scl && p_sda && !sda_l) begin
        in_frame = 1'b1; bitc = 0; bytec = 0; w_nack = 1'b0; wr = 24'h0;
        got_starts++;
      end else if (scl_l && p_scl && !p_sda && sda_l) begin
        if (in_frame) begin
          if (!w_nack && bytec == 3) begin
            got_writes.push_back(wr);
            s_entry++; s_att = 0;
          end else if (w_nack) begin
            s_att++;
          end
        end
        in_frame = 1'b0;
      end else if (in_frame && scl_l && !p_scl) begin
        if (bitc < 8) begin
          sh = {sh[6:0], sda_l};
          bitc++;
        end
      end else if (in_frame && !scl_l && p_scl) begin
        if (bitc == 8) begin
          wr = {wr[15:0], sh};
          w_nack = (nack_pos(s_entry, s_att) == bytec);
          slv_low = !w_nack;
          bitc = 9;
        end else if (bitc == 9) begin
          slv_low = 1'b0;
          bytec++;
          bitc = 0;
        end
      end
      p_scl = scl_l;
      p_sda = sda_l;
    end
  end

  // per-cycle compare against the model timeline
  logic       prev_sda = 1'b0;
  logic [2:0] me;
  logic       md, mer;
  int         qi;

  always @(negedge clk) begin
    if (active) begin
      me = 3'b000; md = 1'b0; mer = 1'b0;
      if (cyc >= INIT_DELAY) begin
        qi = (cyc - INIT_DELAY) / CLK_DIV;
        if (qi < exp_q.size()) me = exp_q[qi];
        else begin
          md  = exp_done;
          mer = exp_err;
        end
      end
      chk("outputs{scl,sda,done,err,px}", 32'({scl_oe, sda_oe, done, error, px_en}),
          32'({me[1], me[0], md, mer, md}));
      if (sda_oe != prev_sda) chk("sda_change_needs_scl_low", 32'(scl_oe | me[2]), 32'd1);
      if (done && done_cyc < 0) done_cyc = cyc;
    end
    prev_sda = sda_oe;
  end

  task automatic start_scn(input int ne, input int nb, input int nt);
    @(negedge clk);
    #2;
    active = 1'b0;
    rst = 1'b1;
    nk_entry = ne; nk_byte = nb; nk_times = nt;
    build_model();
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    done_cyc = -1;
    active = 1'b1;
  endtask

  task automatic finish_scn(input string nm);
    repeat (INIT_DELAY + exp_q.size() * CLK_DIV + 40) @(negedge clk);
    #2;
    chk({nm, "_starts"}, 32'(got_starts), 32'(exp_starts));
    chk({nm, "_nwrites"}, 32'(got_writes.size()), 32'(exp_writes.size()));
    foreach (exp_writes[i])
      if (i < got_writes.size()) chk({nm, "_write"}, 32'(got_writes[i]), 32'(exp_writes[i]));
  endtask

  initial begin
    // all entries acknowledged
    start_scn(-1, 0, 0);
    chk("model_len", 32'(exp_q.size()), 32'd960);
    chk("model_first_write", 32'(exp_writes[0]), 32'h00EC1C00);
    finish_scn("all_ack");
    chk("first_decoded_write", (got_writes.size() > 0) ? 32'(got_writes[0]) : 32'd0, 32'h00EC1C00);
    chk("done_cycle_window", 32'(done_cyc >= 3848 && done_cyc <= 3852), 32'd1);
    chk("final_all_ack", 32'({done, error, px_en}), 32'b101);

    // data byte of entry 3 always NACKed
    start_scn(3, 2, 99);
    finish_scn("nack_e3");
    chk("nack_e3_final", 32'({done, error, px_en}), 32'b010);
    chk("nack_e3_start_count", 32'(got_starts), 32'(4 + MAX_RETRY));

    // entry 2 NACKed twice, then ACKed
    start_scn(2, 1, 2);
    finish_scn("e2_twice");
    chk("e2_twice_start_count", 32'(got_starts), (MAX_RETRY > 0) ? 32'd10 : 32'd3);

    // entry 0 address byte always NACKed
    start_scn(0, 0, 99);
    finish_scn("e0_always");
    chk("e0_always_final", 32'({done, error, px_en}), 32'b010);
    chk("e0_always_start_count", 32'(got_starts), 32'(1 + MAX_RETRY));

    // reset while bit 5 of entry 4's register byte is on the bus
    start_scn(-1, 0, 0);
    chk("model_q540", 32'(exp_q[540]), 32'b011);
    for (int n = 0; n < 6000 && cyc != 2170; n++) @(negedge clk);
    #2;
    chk("reach_entry4_bit5", 32'(cyc), 32'd2170);
    chk("pre_rst_bus", 32'({scl_oe, sda_oe}), 32'b11);
    chk("pre_rst_writes", 32'(got_writes.size()), 32'd4);
    active = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_releases_bus", 32'({scl_oe, sda_oe, done, error, px_en}), 32'd0);
    start_scn(-1, 0, 0);
    finish_scn("after_rst");

    // randomized NACK placement
    for (int r = 0; r < 3; r++) begin
      start_scn(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), int'($urandom_range(1, 4)));
      finish_scn("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
